// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer
// Description : Multi-cycle control unit for a 32-bit single-bus datapath.
//               Fetches through MAR/MDR, decodes IR and drives one datapath
//               transfer step per clock (states IDLE, T0-T7, HALT, FAULT).
//               Optional feature macro: CTRL_MEM_TIMEOUT_EN (memory-wait
//               timeout into a sticky FAULT state).
// Ports       : clk, clr             - clock, synchronous active-high reset
//               i_ir[31:0]           - IR contents (opcode/Ra/Rb/Rc/C)
//               i_mem_rdy            - memory completes current access
//               o_reg_in/o_reg_out   - one-hot register load / bus drive
//               o_pc_out ... o_c_out - datapath strobes
//               o_alu_op[3:0]        - ADD/SUB/AND/OR
//               o_mem_read/o_mem_write, o_run, o_illegal_op, o_fault
// Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] i_ir,
  input  logic        i_mem_rdy,
  output logic [15:0] o_reg_in,
  output logic [15:0] o_reg_out,
  output logic        o_pc_out,
  output logic        o_pc_in,
  output logic        o_inc_pc,
  output logic        o_ir_in,
  output logic        o_mar_in,
  output logic        o_mdr_in,
  output logic        o_mdr_out,
  output logic        o_md_read,
  output logic        o_y_in,
  output logic        o_z_in,
  output logic        o_zlo_out,
  output logic        o_c_out,
  output logic [3:0]  o_alu_op,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic        o_run,
  output logic        o_illegal_op,
  output logic        o_fault
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_T7    = 4'd8,
    S_HALT  = 4'd9,
    S_FAULT = 4'd10
  } state_t;

  localparam logic [4:0] c_OP_LD   = 5'b00000;
  localparam logic [4:0] c_OP_ST   = 5'b00010;
  localparam logic [4:0] c_OP_ADD  = 5'b00011;
  localparam logic [4:0] c_OP_SUB  = 5'b00100;
  localparam logic [4:0] c_OP_AND  = 5'b00101;
  localparam logic [4:0] c_OP_OR   = 5'b00110;
  localparam logic [4:0] c_OP_ADDI = 5'b01100;
  localparam logic [4:0] c_OP_ANDI = 5'b01101;
  localparam logic [4:0] c_OP_ORI  = 5'b01110;
  localparam logic [4:0] c_OP_NOP  = 5'b11010;
  localparam logic [4:0] c_OP_HALT = 5'b11011;

  localparam logic [3:0] c_ALU_ADD = 4'b0000;
  localparam logic [3:0] c_ALU_SUB = 4'b0001;
  localparam logic [3:0] c_ALU_AND = 4'b0010;
  localparam logic [3:0] c_ALU_OR  = 4'b0011;

  state_t r_state;
  state_t w_state_next;

  logic [4:0] w_op;
  logic [3:0] w_ra;
  logic [3:0] w_rb;
  logic [3:0] w_rc;
  logic       w_is_reg;
  logic       w_is_imm;
  logic       w_is_ld;
  logic       w_is_st;
  logic       w_is_alu;
  logic       w_legal;
  logic       w_wait;
  logic       w_timeout;

  assign w_op = i_ir[31:27];
  assign w_ra = i_ir[26:23];
  assign w_rb = i_ir[22:19];
  assign w_rc = i_ir[18:15];

  // Low IR bits carry the immediate, which only the datapath consumes.
  wire w_unused_ir = ^i_ir[14:0];

  assign w_is_reg = (w_op == c_OP_ADD) || (w_op == c_OP_SUB) ||
                    (w_op == c_OP_AND) || (w_op == c_OP_OR);
  assign w_is_imm = (w_op == c_OP_ADDI) || (w_op == c_OP_ANDI) ||
                    (w_op == c_OP_ORI);
  assign w_is_ld  = (w_op == c_OP_LD);
  assign w_is_st  = (w_op == c_OP_ST);
  assign w_is_alu = w_is_reg || w_is_imm;
  assign w_legal  = w_is_alu || w_is_ld || w_is_st ||
                    (w_op == c_OP_NOP) || (w_op == c_OP_HALT);

  // States that hold for a memory handshake.
  assign w_wait = (r_state == S_T1) ||
                  ((r_state == S_T6) && w_is_ld) ||
                  ((r_state == S_T7) && w_is_st);

`ifdef CTRL_MEM_TIMEOUT_EN
  localparam logic [3:0] c_TMO_LAST = 4'(TIMEOUT_CYCLES - 1);
  logic [3:0] r_wait_cnt;

  // Counts consecutive not-ready cycles; any state change restarts it, so
  // each wait state begins from zero.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_wait_cnt <= '0;
    end else if (w_state_next != r_state) begin
      r_wait_cnt <= '0;
    end else if (w_wait) begin
      r_wait_cnt <= r_wait_cnt + 4'd1;
    end
  end

  assign w_timeout = w_wait && !i_mem_rdy && (r_wait_cnt == c_TMO_LAST);
  assign o_fault   = (r_state == S_FAULT);
`else
  wire [31:0] w_unused_timeout = TIMEOUT_CYCLES;
  assign w_timeout = 1'b0;
  assign o_fault   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_reg_in     = '0;
    o_reg_out    = '0;
    o_pc_out     = 1'b0;
    o_pc_in      = 1'b0;
    o_inc_pc     = 1'b0;
    o_ir_in      = 1'b0;
    o_mar_in     = 1'b0;
    o_mdr_in     = 1'b0;
    o_mdr_out    = 1'b0;
    o_md_read    = 1'b0;
    o_y_in       = 1'b0;
    o_z_in       = 1'b0;
    o_zlo_out    = 1'b0;
    o_c_out      = 1'b0;
    o_alu_op     = c_ALU_ADD;
    o_mem_read   = 1'b0;
    o_mem_write  = 1'b0;
    o_illegal_op = 1'b0;

    case (r_state)
      S_IDLE: w_state_next = S_T0;
      S_T0: begin
        o_pc_out     = 1'b1;
        o_mar_in     = 1'b1;
        o_inc_pc     = 1'b1;
        o_z_in       = 1'b1;
        w_state_next = S_T1;
      end
      S_T1: begin
        o_zlo_out  = 1'b1;
        o_pc_in    = 1'b1;
        o_mem_read = 1'b1;
        o_md_read  = 1'b1;
        o_mdr_in   = i_mem_rdy;
        if (i_mem_rdy) w_state_next = S_T2;
      end
      S_T2: begin
        o_mdr_out    = 1'b1;
        o_ir_in      = 1'b1;
        w_state_next = S_T3;
      end
      S_T3: begin
        if (w_op == c_OP_HALT) begin
          w_state_next = S_HALT;
        end else if (w_op == c_OP_NOP) begin
          w_state_next = S_T0;
        end else if (!w_legal) begin
          o_illegal_op = 1'b1;
          w_state_next = S_T0;
        end else begin
          o_reg_out    = 16'd1 << w_rb;
          o_y_in       = 1'b1;
          w_state_next = S_T4;
        end
      end
      S_T4: begin
        o_z_in = 1'b1;
        if (w_is_reg) begin
          o_reg_out = 16'd1 << w_rc;
          case (w_op)
            c_OP_SUB: o_alu_op = c_ALU_SUB;
            c_OP_AND: o_alu_op = c_ALU_AND;
            c_OP_OR:  o_alu_op = c_ALU_OR;
            default:  o_alu_op = c_ALU_ADD;
          endcase
        end else begin
          // Immediates and ld/st address calculation take C on the bus.
          o_c_out = 1'b1;
          if (w_op == c_OP_ANDI) begin
            o_alu_op = c_ALU_AND;
          end else if (w_op == c_OP_ORI) begin
            o_alu_op = c_ALU_OR;
          end else begin
            o_alu_op = c_ALU_ADD;
          end
        end
        w_state_next = S_T5;
      end
      S_T5: begin
        o_zlo_out = 1'b1;
        if (w_is_alu) begin
          o_reg_in     = 16'd1 << w_ra;
          w_state_next = S_T0;
        end else begin
          o_mar_in     = 1'b1;
          w_state_next = S_T6;
        end
      end
      S_T6: begin
        if (w_is_ld) begin
          o_mem_read = 1'b1;
          o_md_read  = 1'b1;
          o_mdr_in   = i_mem_rdy;
          if (i_mem_rdy) w_state_next = S_T7;
        end else begin
          o_reg_out    = 16'd1 << w_ra;
          o_mdr_in     = 1'b1;
          w_state_next = S_T7;
        end
      end
      S_T7: begin
        if (w_is_ld) begin
          o_mdr_out    = 1'b1;
          o_reg_in     = 16'd1 << w_ra;
          w_state_next = S_T0;
        end else begin
          o_mem_write = 1'b1;
          if (i_mem_rdy) w_state_next = S_T0;
        end
      end
      S_HALT:  w_state_next = S_HALT;
      S_FAULT: w_state_next = S_FAULT;
      default: w_state_next = S_IDLE;
    endcase

    if (w_timeout) w_state_next = S_FAULT;
  end

  assign o_run = (r_state != S_IDLE) && (r_state != S_HALT) &&
                 (r_state != S_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_sequencer
// Description : Self-checking bench for control_sequencer. A reference model
//               expands each instruction into its expected per-cycle output
//               steps; a driver applies the steps and queues the expectations,
//               and an independent monitor pops and compares every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

  typedef struct packed {
    logic [15:0] reg_in;
    logic [15:0] reg_out;
    logic pc_out, pc_in, inc_pc, ir_in, mar_in, mdr_in, mdr_out, md_read;
    logic y_in, z_in, zlo_out, c_out;
    logic [3:0] alu_op;
    logic mem_read, mem_write, run, illegal_op, fault;
  } outs_t;

  typedef struct {
    logic        clr;
    logic        rdy;
    logic [31:0] ir;
    outs_t       exp;
  } step_t;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        mem_rdy = 1'b0;
  logic [31:0] ir = '0;

  logic [15:0] reg_in, reg_out;
  logic pc_out, pc_in, inc_pc, ir_in, mar_in, mdr_in, mdr_out, md_read;
  logic y_in, z_in, zlo_out, c_out;
  logic [3:0] alu_op;
  logic mem_read, mem_write, run, illegal_op, fault;

  control_sequencer #(.TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .clr(clr), .i_ir(ir), .i_mem_rdy(mem_rdy),
    .o_reg_in(reg_in), .o_reg_out(reg_out),
    .o_pc_out(pc_out), .o_pc_in(pc_in), .o_inc_pc(inc_pc), .o_ir_in(ir_in),
    .o_mar_in(mar_in), .o_mdr_in(mdr_in), .o_mdr_out(mdr_out),
    .o_md_read(md_read), .o_y_in(y_in), .o_z_in(z_in), .o_zlo_out(zlo_out),
    .o_c_out(c_out), .o_alu_op(alu_op), .o_mem_read(mem_read),
    .o_mem_write(mem_write), .o_run(run), .o_illegal_op(illegal_op),
    .o_fault(fault)
  );

  always #5 clk = ~clk;

  outs_t act;
  assign act = {reg_in, reg_out, pc_out, pc_in, inc_pc, ir_in, mar_in, mdr_in,
                mdr_out, md_read, y_in, z_in, zlo_out, c_out, alu_op,
                mem_read, mem_write, run, illegal_op, fault};

  step_t plan[$];
  outs_t exp_q[$];
  outs_t mon_e;
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;

  // ---------------- reference model ----------------
  localparam logic [4:0] LD = 5'b00000, ST = 5'b00010, ADD = 5'b00011,
    SUB = 5'b00100, ANDR = 5'b00101, ORR = 5'b00110, ADDI = 5'b01100,
    ANDI = 5'b01101, ORI = 5'b01110, NOP = 5'b11010, HALT = 5'b11011;

  function automatic bit legal(input logic [4:0] op);
    return op inside {LD, ST, ADD, SUB, ANDR, ORR, ADDI, ANDI, ORI, NOP, HALT};
  endfunction

  function automatic logic [3:0] alu_code(input logic [4:0] op);
    case (op)
      SUB, ANDR: return (op == SUB) ? 4'b0001 : 4'b0010;
      ORR, ORI:  return 4'b0011;
      ANDI:      return 4'b0010;
      default:   return 4'b0000;
    endcase
  endfunction

  function automatic outs_t running();
    outs_t o = '0;
    o.run = 1'b1;
    return o;
  endfunction

  task automatic push(input outs_t o, input logic c, input logic r,
                      input logic [31:0] irv);
    step_t s;
    s.clr = c; s.rdy = r; s.ir = irv; s.exp = o;
    plan.push_back(s);
  endtask

  task automatic push_idle();
    push('0, 1'b0, 1'($urandom), $urandom);
  endtask

  // Expands one instruction. w1/w2 = not-ready cycles in the fetch wait and
  // the ld/st memory wait; clr_wait asserts clr on the last ld memory wait.
  task automatic add_instr(input logic [31:0] instr, input int w1,
                           input int w2, input bit clr_wait);
    logic [4:0] op = instr[31:27];
    logic [3:0] ra = instr[26:23];
    logic [3:0] rb = instr[22:19];
    logic [3:0] rc = instr[18:15];
    bit is_reg = op inside {ADD, SUB, ANDR, ORR};
    bit is_imm = op inside {ADDI, ANDI, ORI};
    outs_t o;
    // fetch: IR still holds stale contents, so feed junk
    o = running(); o.pc_out = 1; o.mar_in = 1; o.inc_pc = 1; o.z_in = 1;
    push(o, 0, 1'($urandom), $urandom);
    o = running(); o.zlo_out = 1; o.pc_in = 1; o.mem_read = 1; o.md_read = 1;
    for (int i = 0; i < w1; i++) push(o, 0, 0, $urandom);
    o.mdr_in = 1;
    push(o, 0, 1, $urandom);
    o = running(); o.mdr_out = 1; o.ir_in = 1;
    push(o, 0, 1'($urandom), $urandom);
    // decode
    o = running();
    if (op == HALT || op == NOP) begin
      push(o, 0, 1'($urandom), instr);
      return;
    end
    if (!legal(op)) begin
      o.illegal_op = 1;
      push(o, 0, 1'($urandom), instr);
      return;
    end
    o.reg_out = 16'd1 << rb; o.y_in = 1;
    push(o, 0, 1'($urandom), instr);
    o = running(); o.z_in = 1; o.alu_op = alu_code(op);
    if (is_reg) o.reg_out = 16'd1 << rc;
    else        o.c_out = 1;
    push(o, 0, 1'($urandom), instr);
    o = running(); o.zlo_out = 1;
    if (is_reg || is_imm) begin
      o.reg_in = 16'd1 << ra;
      push(o, 0, 1'($urandom), instr);
      return;
    end
    o.mar_in = 1;
    push(o, 0, 1'($urandom), instr);
    if (op == LD) begin
      o = running(); o.mem_read = 1; o.md_read = 1;
      for (int i = 0; i < w2; i++)
        push(o, (clr_wait && i == w2 - 1), 0, instr);
      if (clr_wait) begin
        push_idle();
        return;
      end
      o.mdr_in = 1;
      push(o, 0, 1, instr);
      o = running(); o.mdr_out = 1; o.reg_in = 16'd1 << ra;
      push(o, 0, 1'($urandom), instr);
    end else begin
      o = running(); o.reg_out = 16'd1 << ra; o.mdr_in = 1;
      push(o, 0, 1'($urandom), instr);
      o = running(); o.mem_write = 1;
      for (int i = 0; i < w2; i++) push(o, 0, 0, instr);
      push(o, 0, 1, instr);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] ops[10] = '{LD, ST, ADD, SUB, ANDR, ORR, ADDI, ANDI, ORI, NOP};
    logic [4:0] op;
    logic [31:0] r = $urandom;
    if ($urandom_range(0, 9) == 0) begin
      do op = 5'($urandom); while (legal(op));
    end else begin
      op = ops[$urandom_range(0, 9)];
    end
    return {op, r[26:0]};
  endfunction

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        n_checks++;
        if (act !== mon_e) begin
          n_fail++;
          $display("FAIL outputs cycle %0d: got %h expected %h", cyc, act, mon_e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // reset held two cycles, then one IDLE cycle
    push('0, 1, 1'($urandom), $urandom);
    push('0, 1, 1'($urandom), $urandom);
    push_idle();
    add_instr({ADD, 4'd3, 4'd1, 4'd2, 15'd0}, 0, 0, 0);
    add_instr({ADDI, 4'd5, 4'd2, 19'h00007}, 0, 0, 0);
    add_instr({LD, 4'd4, 4'd1, 19'd16}, 0, 3, 0);
    add_instr({ST, 4'd6, 4'd2, 19'd8}, 1, 2, 0);
    add_instr({5'b11111, 27'h0123456}, 0, 0, 0);
    add_instr({NOP, 27'h7654321}, 2, 0, 0);
    for (int k = 0; k < 40; k++)
      add_instr(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 3), 0);
    // reset in the middle of an ld memory wait
    add_instr({LD, 4'd7, 4'd3, 19'd4}, 0, 2, 1);
    add_instr({ORR, 4'd15, 4'd0, 4'd14, 15'd0}, 0, 0, 0);
    // halt is absorbing until clr
    add_instr({HALT, 27'h0}, 0, 0, 0);
    for (int i = 0; i < 22; i++) push('0, (i == 21), 1'($urandom), $urandom);
    push_idle();
    add_instr({ORI, 4'd1, 4'd9, 19'h3}, 0, 0, 0);
`ifdef CTRL_MEM_TIMEOUT_EN
    begin
      outs_t o;
      o = running(); o.pc_out = 1; o.mar_in = 1; o.inc_pc = 1; o.z_in = 1;
      push(o, 0, 0, $urandom);
      o = running(); o.zlo_out = 1; o.pc_in = 1; o.mem_read = 1; o.md_read = 1;
      for (int i = 0; i < 15; i++) push(o, 0, 0, $urandom);
      o = '0; o.fault = 1;
      for (int i = 0; i < 5; i++) push(o, (i == 4), 1'($urandom), $urandom);
      push_idle();
    end
`endif

    for (int i = 0; i < plan.size(); i++) begin
      @(posedge clk);
      #1;
      clr     = plan[i].clr;
      mem_rdy = plan[i].rdy;
      ir      = plan[i].ir;
      exp_q.push_back(plan[i].exp);
    end
    @(posedge clk);
    #1;
    clr = 1'b1;
    repeat (2) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/control_sequencer.md
# control_sequencer

Multi-cycle control unit for the 32-bit bus-based datapath. It fetches an instruction through MAR/MDR, decodes the IR, and drives the one-hot register in/out strobes, the Y/Z/PC/IR/MAR/MDR load and drive enables, the ALU operation code and the memory read/write handshake, one datapath transfer step per clock. It sits beside the datapath and owns every enable and bus-select line that the datapath consumes.

## Interface
- TIMEOUT_CYCLES, 15: memory wait limit in cycles; used only with CTRL_MEM_TIMEOUT_EN.

- clk  in  1  rising-edge clock.
- clr  in  1  synchronous active-high reset.
- ir  in  32  IR register output. Fields: opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15], C [18:0].
- mem_rdy  in  1  memory completes the current read or write in this cycle.
- reg_in  out  16  one-hot Rn load enable.
- reg_out  out  16  one-hot Rn bus drive.
- pc_out, pc_in, inc_pc, ir_in, mar_in, mdr_in, mdr_out, md_read, y_in, z_in, zlo_out, c_out  out  1 each  datapath strobes.
- alu_op  out  4  ALU operation code: ADD=0000, SUB=0001, AND=0010, OR=0011.
- mem_read, mem_write  out  1  memory request.
- run  out  1  high while the sequencer is executing.
- illegal_op  out  1  one-cycle pulse on an unknown opcode.
- fault  out  1  sticky memory timeout flag.

## Operation
- Opcodes: ld 00000, st 00010, add 00011, sub 00100, and 00101, or 00110, addi 01100, andi 01101, ori 01110, nop 11010, halt 11011. All other opcodes are illegal.
- States: IDLE, T0–T7, HALT, FAULT. The state is registered. All outputs decode combinationally from the state and ir. Any strobe not listed for a state is 0.
- IDLE: no outputs asserted. Next state is T0.
- T0: pc_out, mar_in, inc_pc, z_in.
- T1: zlo_out, pc_in, mem_read, md_read. mdr_in = mem_rdy. Stay in T1 while mem_rdy=0; go to T2 when mem_rdy=1.
- T2: mdr_out, ir_in.
- T3 (decode):
  - halt goes to HALT; nop goes to T0. Neither asserts outputs.
  - Illegal opcode: pulse illegal_op, go to T0.
  - Otherwise: reg_out[Rb], y_in.
- T4:
  - Register ops: reg_out[Rc], z_in, alu_op per opcode.
  - Immediate ops and ld/st: c_out, z_in. alu_op is ADD for addi/ld/st, AND for andi, OR for ori.
- T5:
  - ALU ops: zlo_out, reg_in[Ra]. Next state is T0.
  - ld/st: zlo_out, mar_in. Next state is T6.
- T6:
  - ld: mem_read, md_read, mdr_in = mem_rdy. Wait for mem_rdy, then go to T7.
  - st: reg_out[Ra], mdr_in with md_read=0. Next state is T7.
- T7:
  - ld: mdr_out, reg_in[Ra]. Next state is T0.
  - st: mem_write. Wait for mem_rdy, then go to T0.
- HALT and FAULT are absorbing. Only clr leaves them. run=0 in IDLE, HALT and FAULT, and run=1 in all other states.
- reg_in and reg_out are always zero or exactly one-hot.

## Timing
- clr sampled high on an edge sends the state to IDLE and clears fault. This applies from any state, including a memory wait. mem_read and mem_write drop in the same cycle.
- Reset values: every output is 0.
- Minimum cycle counts, with mem_rdy high on first request:
  - ALU and immediate ops: 6 cycles (T0–T5).
  - ld: 8 cycles.
  - st: 8 cycles.
  - nop and halt: 4 cycles.
- Every cycle in which mem_rdy is low during T1, ld-T6 or st-T7 adds one cycle.
- mem_read and mem_write stay asserted and stable until the cycle in which mem_rdy=1.
- A mem_rdy outside a wait state is ignored.
- IR is loaded at the end of T2. ir is first trusted in T3.

## Configuration
- CTRL_MEM_TIMEOUT_EN defined:
  - A 4-bit wait counter runs in T1, ld-T6 and st-T7. It clears on entry to each of these states.
  - If TIMEOUT_CYCLES consecutive cycles pass with mem_rdy=0, the next state is FAULT: fault=1, all strobes 0.
- CTRL_MEM_TIMEOUT_EN not defined: no counter, and waits are unbounded. fault is tied to 0.

## Test plan
- add R3,R1,R2 with mem_rdy always 1 → T3 has reg_out=0x0002 and y_in; T4 has reg_out=0x0004, alu_op=0000, z_in; T5 has reg_in=0x0008. Total 6 cycles.
- addi R5,R2,0x00007 → T4 has c_out=1, alu_op=0000; T5 has reg_in=0x0020. No reg_out in T4.
- ld R4 with mem_rdy low for 3 cycles in T6 → mem_read held 4 cycles; mdr_in only in the mem_rdy cycle; T7 has reg_in=0x0010. Total 11 cycles.
- st R6 → T6 has reg_out=0x0040, mdr_in=1, md_read=0; T7 has mem_write held until mem_rdy.
- Opcode 11111 → illegal_op high for exactly 1 cycle in T3, then T0. halt → run=0, remains in HALT for 20+ cycles.
- clr asserted during ld-T6 wait → next cycle all outputs 0. With CTRL_MEM_TIMEOUT_EN and mem_rdy=0 held for 15 cycles in T1 → fault=1.
